// File: rtl/char_term_ctrl.sv
// Terminal-style character sequencer: turns a valid/ready ASCII byte stream into VRAM cell writes,
// with cursor control, auto-wrap, ring-buffer scrolling and full-screen clear.
module char_term_ctrl #(
  parameter int unsigned NUM_COLS      = 80,
  parameter int unsigned NUM_ROWS      = 50,
  parameter logic [15:0] CONF_ADDR     = 16'h4000,
  parameter logic [11:0] DEFAULT_COLOR = 12'hFFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CH_VALID,
  output logic        CH_READY,
  input  logic [7:0]  CH_DATA,
  input  logic [11:0] ATTR_COLOR,
  input  logic        ATTR_INV,
  input  logic        ATTR_BLINK,
  input  logic        CLEAR_REQ,
  output logic [15:0] WRITE_ADDR,
  output logic [3:0]  BYTE_EN,
  output logic        WRITE_EN,
  output logic [31:0] WRITE_DATA,
  output logic        BUSY,
  output logic [6:0]  CUR_COL,
  output logic [5:0]  CUR_ROW,
  output logic [5:0]  SCROLL_OFS
);

  localparam int unsigned COL_W = 7;
  localparam int unsigned ROW_W = 6;
  localparam int unsigned IDX_W = 12;
  localparam int unsigned CELLS = NUM_COLS * NUM_ROWS;
  localparam logic [31:0] FILL_DATA = {8'h0, 2'b0, 1'b0, 1'b0, DEFAULT_COLOR, 1'b0, 7'h20};

  typedef enum logic [2:0] {S_IDLE, S_PUT, S_MOVE, S_SCRL, S_CONF, S_CLRALL} state_t;

  state_t             state_q;
  logic               live_q;
  logic               scroll_pend_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   ofs_q;
  logic [15:0]        addr_q;
  logic [3:0]         be_q;
  logic               we_q;
  logic [31:0]        data_q;

  logic               is_print;
  logic               need_scroll;
  logic               newline;
  logic [COL_W-1:0]   col_d;
  logic [ROW_W-1:0]   row_d;
  logic [ROW_W-1:0]   ofs_next;

  // Logical (row, col) to VRAM cell index through the ring offset.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] ofs,
                                                input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    logic [ROW_W:0] phys;
    phys = {1'b0, ofs} + {1'b0, row};
    if (phys >= (ROW_W+1)'(NUM_ROWS)) phys = phys - (ROW_W+1)'(NUM_ROWS);
    return IDX_W'(phys) * IDX_W'(NUM_COLS) + IDX_W'(col);
  endfunction

  function automatic logic [15:0] byte_addr(input logic [IDX_W-1:0] idx);
    return 16'({idx, 2'b00});
  endfunction

  // Cursor effect of the byte currently offered on CH_DATA.
  always_comb begin
    is_print    = (CH_DATA >= 8'h20) && (CH_DATA <= 8'h7E);
    col_d       = col_q;
    row_d       = row_q;
    newline     = 1'b0;
    need_scroll = 1'b0;
    if (is_print) begin
      if (col_q == COL_W'(NUM_COLS - 1)) begin
        col_d   = '0;
        newline = 1'b1;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      case (CH_DATA)
        8'h0A: begin
          col_d   = '0;
          newline = 1'b1;
        end
        8'h0D: col_d = '0;
        8'h08: if (col_q != '0) col_d = col_q - COL_W'(1);
        default: ;
      endcase
    end
    if (newline) begin
      if (row_q == ROW_W'(NUM_ROWS - 1)) need_scroll = 1'b1;
      else                               row_d = row_q + ROW_W'(1);
    end
    ofs_next = (ofs_q == ROW_W'(NUM_ROWS - 1)) ? '0 : ofs_q + ROW_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      live_q        <= 1'b0;
      scroll_pend_q <= 1'b0;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      ofs_q         <= '0;
      addr_q        <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      data_q        <= '0;
    end else begin
      live_q <= 1'b1;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CLEAR_REQ) begin
            state_q <= S_CLRALL;
            we_q    <= 1'b1;
            addr_q  <= '0;
            be_q    <= 4'b0111;
            data_q  <= FILL_DATA;
            cnt_q   <= IDX_W'(1);
          end else if (CH_VALID && live_q) begin
            col_q         <= col_d;
            row_q         <= row_d;
            scroll_pend_q <= need_scroll;
            if (is_print) begin
              state_q <= S_PUT;
              we_q    <= 1'b1;
              addr_q  <= byte_addr(cell_idx(ofs_q, row_q, col_q));
              be_q    <= 4'b0111;
              data_q  <= {8'h0, 2'b0, ATTR_BLINK, ATTR_INV, ATTR_COLOR, 1'b0, CH_DATA[6:0]};
            end else begin
              state_q <= S_MOVE;
            end
          end
        end
        S_PUT, S_MOVE: begin
          if (scroll_pend_q) begin
            state_q <= S_SCRL;
            we_q    <= 1'b1;
            addr_q  <= byte_addr(cell_idx(ofs_q, '0, '0));
            be_q    <= 4'b0111;
            data_q  <= FILL_DATA;
            cnt_q   <= IDX_W'(1);
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SCRL: begin
          if (cnt_q < IDX_W'(NUM_COLS)) begin
            we_q   <= 1'b1;
            addr_q <= byte_addr(cell_idx(ofs_q, '0, '0) + cnt_q);
            cnt_q  <= cnt_q + IDX_W'(1);
          end else begin
            state_q <= S_CONF;
            ofs_q   <= ofs_next;
            we_q    <= 1'b1;
            addr_q  <= CONF_ADDR;
            be_q    <= 4'b0001;
            data_q  <= 32'(ofs_next);
          end
        end
        S_CLRALL: begin
          if (cnt_q < IDX_W'(CELLS)) begin
            we_q   <= 1'b1;
            addr_q <= byte_addr(cnt_q);
            cnt_q  <= cnt_q + IDX_W'(1);
          end else begin
            state_q <= S_CONF;
            ofs_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b1;
            addr_q  <= CONF_ADDR;
            be_q    <= 4'b0001;
            data_q  <= '0;
          end
        end
        S_CONF:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CH_READY   = live_q && (state_q == S_IDLE) && !CLEAR_REQ;
  assign BUSY       = (state_q != S_IDLE);
  assign WRITE_EN   = we_q;
  assign WRITE_ADDR = addr_q;
  assign BYTE_EN    = be_q;
  assign WRITE_DATA = data_q;
  assign CUR_COL    = col_q;
  assign CUR_ROW    = row_q;
  assign SCROLL_OFS = ofs_q;

endmodule

// File: tb/tb_char_term_ctrl.sv
// Directed self-checking bench for char_term_ctrl: printing, control codes, wrap, scroll, clear, reset.
module tb_char_term_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CH_VALID = 1'b0;
  logic        CH_READY;
  logic [7:0]  CH_DATA = 8'h0;
  logic [11:0] ATTR_COLOR = 12'hFFF;
  logic        ATTR_INV = 1'b0;
  logic        ATTR_BLINK = 1'b0;
  logic        CLEAR_REQ = 1'b0;
  logic [15:0] WRITE_ADDR;
  logic [3:0]  BYTE_EN;
  logic        WRITE_EN;
  logic [31:0] WRITE_DATA;
  logic        BUSY;
  logic [6:0]  CUR_COL;
  logic [5:0]  CUR_ROW;
  logic [5:0]  SCROLL_OFS;

  int errors = 0;
  int checks = 0;

  logic [15:0] wa[$];
  logic [31:0] wd[$];
  logic [3:0]  wb[$];

  char_term_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .CH_VALID(CH_VALID), .CH_READY(CH_READY), .CH_DATA(CH_DATA),
    .ATTR_COLOR(ATTR_COLOR), .ATTR_INV(ATTR_INV), .ATTR_BLINK(ATTR_BLINK), .CLEAR_REQ(CLEAR_REQ),
    .WRITE_ADDR(WRITE_ADDR), .BYTE_EN(BYTE_EN), .WRITE_EN(WRITE_EN), .WRITE_DATA(WRITE_DATA),
    .BUSY(BUSY), .CUR_COL(CUR_COL), .CUR_ROW(CUR_ROW), .SCROLL_OFS(SCROLL_OFS)
  );

  always #5 CLK = ~CLK;

  // Log every write strobe seen away from the active edge.
  always @(negedge CLK) begin
    if (WRITE_EN === 1'b1) begin
      wa.push_back(WRITE_ADDR);
      wd.push_back(WRITE_DATA);
      wb.push_back(BYTE_EN);
    end
  end

  task automatic clr_log();
    wa.delete(); wd.delete(); wb.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: BUSY=%b after %0d cycles, need 0", BUSY, n);
    end
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [11:0] color = 12'hFFF,
                      input logic inv = 1'b0, input logic blink = 1'b0, input int budget = 200);
    int n = 0;
    @(negedge CLK);
    while (CH_READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (CH_READY !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_ready: CH_READY=%b, need 1", CH_READY);
    end
    CH_VALID = 1'b1; CH_DATA = c; ATTR_COLOR = color; ATTR_INV = inv; ATTR_BLINK = blink;
    @(negedge CLK);
    CH_VALID = 1'b0;
    wait_idle(budget);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    clr_log();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (CH_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b need 0", CH_READY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", BUSY); end
    checks++; if (WRITE_EN !== 1'b0) begin errors++; $display("FAIL rst_we: got %b need 0", WRITE_EN); end
    checks++; if ({WRITE_ADDR, BYTE_EN, WRITE_DATA} !== 52'h0) begin errors++; $display("FAIL rst_bus: got %h need 0", {WRITE_ADDR, BYTE_EN, WRITE_DATA}); end
    checks++; if ({CUR_COL, CUR_ROW, SCROLL_OFS} !== 19'h0) begin errors++; $display("FAIL rst_cursor: got %h need 0", {CUR_COL, CUR_ROW, SCROLL_OFS}); end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (CH_READY !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b need 1", CH_READY); end
    clr_log();
  endtask

  task automatic test_put();
    send(8'h41, 12'hF00);
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL put_count: got %0d need 1", wa.size()); end
    else begin
      checks++; if (wa[0] !== 16'h0000) begin errors++; $display("FAIL put_addr: got %h need 0000", wa[0]); end
      checks++; if (wd[0] !== 32'h000F0041) begin errors++; $display("FAIL put_data: got %h need 000f0041", wd[0]); end
      checks++; if (wb[0] !== 4'b0111) begin errors++; $display("FAIL put_be: got %b need 0111", wb[0]); end
    end
    checks++; if (CUR_COL !== 7'd1) begin errors++; $display("FAIL put_col: got %0d need 1", CUR_COL); end
    clr_log();
    send(8'h62, 12'h123, 1'b1, 1'b0);
    checks++; if (wa.size() != 1 || wa[0] !== 16'h0004 || wd[0] !== 32'h00112362) begin
      errors++; $display("FAIL put_attr: n=%0d addr=%h data=%h need 1/0004/00112362", wa.size(), wa.size() ? wa[0] : 16'hx, wd.size() ? wd[0] : 32'hx);
    end
    clr_log();
    send(8'h43, 12'h000, 1'b0, 1'b1);
    checks++; if (wa.size() != 1 || wa[0] !== 16'h0008 || wd[0] !== 32'h00200043) begin
      errors++; $display("FAIL put_blink: n=%0d addr=%h data=%h need 1/0008/00200043", wa.size(), wa.size() ? wa[0] : 16'hx, wd.size() ? wd[0] : 32'hx);
    end
    clr_log();
  endtask

  task automatic test_ctrl();
    send(8'h0D);
    checks++; if (CUR_COL !== 7'd0 || wa.size() != 0) begin errors++; $display("FAIL cr_col3: col=%0d writes=%0d need 0/0", CUR_COL, wa.size()); end
    send(8'h08);
    checks++; if (CUR_COL !== 7'd0 || CUR_ROW !== 6'd0 || wa.size() != 0) begin errors++; $display("FAIL bs_col0: col=%0d row=%0d writes=%0d need 0/0/0", CUR_COL, CUR_ROW, wa.size()); end
    for (int i = 0; i < 37; i++) send(8'h78);
    checks++; if (CUR_COL !== 7'd37) begin errors++; $display("FAIL col37: got %0d need 37", CUR_COL); end
    clr_log();
    send(8'h0D);
    checks++; if (CUR_COL !== 7'd0 || CUR_ROW !== 6'd0 || wa.size() != 0) begin errors++; $display("FAIL cr_col37: col=%0d row=%0d writes=%0d need 0/0/0", CUR_COL, CUR_ROW, wa.size()); end
    send(8'h0A);
    checks++; if (CUR_COL !== 7'd0 || CUR_ROW !== 6'd1 || wa.size() != 0) begin errors++; $display("FAIL lf: col=%0d row=%0d writes=%0d need 0/1/0", CUR_COL, CUR_ROW, wa.size()); end
    send(8'h61); send(8'h62); send(8'h08);
    send(8'h07); send(8'h7F);
    checks++; if (CUR_COL !== 7'd1 || wa.size() != 2) begin errors++; $display("FAIL bs_other: col=%0d writes=%0d need 1/2", CUR_COL, wa.size()); end
    clr_log();
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[4];
    int i = 0;
    int cyc = 0;
    s[0] = 8'h70; s[1] = 8'h71; s[2] = 8'h72; s[3] = 8'h73;
    @(negedge CLK);
    CH_VALID = 1'b1; CH_DATA = s[0]; ATTR_COLOR = 12'hFFF; ATTR_INV = 1'b0; ATTR_BLINK = 1'b0;
    while (i < 4 && cyc < 40) begin
      if (CH_READY === 1'b1) begin
        @(negedge CLK);
        i++;
        if (i < 4) CH_DATA = s[i];
      end else begin
        @(negedge CLK);
      end
      cyc++;
    end
    CH_VALID = 1'b0;
    wait_idle(20);
    checks++; if (cyc != 7) begin errors++; $display("FAIL b2b_cycles: got %0d need 7", cyc); end
    checks++; if (wa.size() != 4 || wa[0] !== 16'h0144 || wa[3] !== 16'h0150 || wd[3] !== 32'h000FFF73) begin
      errors++; $display("FAIL b2b_writes: n=%0d first=%h last=%h need 4/0144/0150", wa.size(), wa.size() ? wa[0] : 16'hx, wa.size() ? wa[wa.size()-1] : 16'hx);
    end
    clr_log();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 80; i++) send(8'h41 + 8'(i % 26));
    checks++; if (wa.size() != 80 || wa[79] !== 16'h013C) begin errors++; $display("FAIL wrap_last: n=%0d last=%h need 80/013c", wa.size(), wa.size() ? wa[wa.size()-1] : 16'hx); end
    checks++; if (CUR_COL !== 7'd0 || CUR_ROW !== 6'd1 || SCROLL_OFS !== 6'd0) begin errors++; $display("FAIL wrap_cursor: col=%0d row=%0d ofs=%0d need 0/1/0", CUR_COL, CUR_ROW, SCROLL_OFS); end
    clr_log();
  endtask

  task automatic test_scroll();
    int bad = 0;
    for (int i = 0; i < 48; i++) send(8'h0A);
    checks++; if (CUR_ROW !== 6'd49 || wa.size() != 0) begin errors++; $display("FAIL row49: row=%0d writes=%0d need 49/0", CUR_ROW, wa.size()); end
    send(8'h0A);
    checks++; if (wa.size() != 81) begin errors++; $display("FAIL scroll_count: got %0d need 81", wa.size()); end
    else begin
      for (int i = 0; i < 80; i++)
        if (wa[i] !== 16'(i * 4) || wd[i] !== 32'h000FFF20 || wb[i] !== 4'b0111) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL scroll_cells: bad=%0d need 0", bad); end
      checks++; if (wa[80] !== 16'h4000 || wd[80] !== 32'd1 || wb[80] !== 4'b0001) begin errors++; $display("FAIL scroll_conf: addr=%h data=%h be=%b need 4000/1/0001", wa[80], wd[80], wb[80]); end
    end
    checks++; if (SCROLL_OFS !== 6'd1 || CUR_ROW !== 6'd49 || CUR_COL !== 7'd0) begin errors++; $display("FAIL scroll_state: ofs=%0d row=%0d col=%0d need 1/49/0", SCROLL_OFS, CUR_ROW, CUR_COL); end
    clr_log();
  endtask

  task automatic test_ofs_wrap();
    for (int i = 0; i < 48; i++) send(8'h0A);
    checks++; if (SCROLL_OFS !== 6'd49) begin errors++; $display("FAIL ofs49: got %0d need 49", SCROLL_OFS); end
    clr_log();
    send(8'h5A, 12'h0F0);
    checks++; if (wa.size() != 1 || wa[0] !== 16'h3C00 || wd[0] !== 32'h0000F05A) begin
      errors++; $display("FAIL ofs49_put: n=%0d addr=%h data=%h need 1/3c00/0000f05a", wa.size(), wa.size() ? wa[0] : 16'hx, wd.size() ? wd[0] : 32'hx);
    end
    clr_log();
    send(8'h0A);
    checks++; if (wa.size() != 81 || wa[0] !== 16'h3D40 || wa[79] !== 16'h3E7C || wd[80] !== 32'd0) begin
      errors++; $display("FAIL ofs_wrap_scroll: n=%0d first=%h need 81/3d40", wa.size(), wa.size() ? wa[0] : 16'hx);
    end
    checks++; if (SCROLL_OFS !== 6'd0) begin errors++; $display("FAIL ofs_wrap: got %0d need 0", SCROLL_OFS); end
    clr_log();
    send(8'h51);
    checks++; if (wa.size() != 1 || wa[0] !== 16'h3D40 || wd[0] !== 32'h000FFF51) begin
      errors++; $display("FAIL ofs0_row49_put: n=%0d addr=%h need 1/3d40", wa.size(), wa.size() ? wa[0] : 16'hx);
    end
    send(8'h0A);
    clr_log();
  endtask

  task automatic test_clear();
    int bad = 0;
    send(8'h4D);
    clr_log();
    @(negedge CLK);
    CLEAR_REQ = 1'b1;
    CH_VALID = 1'b1; CH_DATA = 8'h4E;
    #1;
    checks++; if (CH_READY !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b need 0", CH_READY); end
    @(negedge CLK);
    CLEAR_REQ = 1'b0;
    CH_VALID = 1'b0;
    wait_idle(5000);
    checks++; if (wa.size() != 4001) begin errors++; $display("FAIL clear_count: got %0d need 4001", wa.size()); end
    else begin
      for (int i = 0; i < 4000; i++)
        if (wa[i] !== 16'(i * 4) || wd[i] !== 32'h000FFF20 || wb[i] !== 4'b0111) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL clear_cells: bad=%0d need 0", bad); end
      checks++; if (wa[4000] !== 16'h4000 || wd[4000] !== 32'd0 || wb[4000] !== 4'b0001) begin errors++; $display("FAIL clear_conf: addr=%h data=%h be=%b need 4000/0/0001", wa[4000], wd[4000], wb[4000]); end
    end
    checks++; if ({CUR_COL, CUR_ROW, SCROLL_OFS} !== 19'h0) begin errors++; $display("FAIL clear_cursor: col=%0d row=%0d ofs=%0d need 0/0/0", CUR_COL, CUR_ROW, SCROLL_OFS); end
    clr_log();
  endtask

  task automatic test_reset_mid();
    send(8'h41);
    @(negedge CLK);
    CLEAR_REQ = 1'b1;
    @(negedge CLK);
    CLEAR_REQ = 1'b0;
    repeat (50) @(negedge CLK);
    checks++; if (WRITE_EN !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL clrall_active: we=%b busy=%b need 1/1", WRITE_EN, BUSY); end
    RST_N = 1'b0;
    @(negedge CLK);
    clr_log();
    checks++; if (WRITE_EN !== 1'b0 || BUSY !== 1'b0 || CH_READY !== 1'b0) begin errors++; $display("FAIL midrst_ctl: we=%b busy=%b rdy=%b need 0/0/0", WRITE_EN, BUSY, CH_READY); end
    checks++; if ({WRITE_ADDR, BYTE_EN, WRITE_DATA, CUR_COL, CUR_ROW, SCROLL_OFS} !== 71'h0) begin errors++; $display("FAIL midrst_outs: got %h need 0", {WRITE_ADDR, BYTE_EN, WRITE_DATA, CUR_COL, CUR_ROW, SCROLL_OFS}); end
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    checks++; if (wa.size() != 0 || CH_READY !== 1'b1) begin errors++; $display("FAIL midrst_after: writes=%0d rdy=%b need 0/1", wa.size(), CH_READY); end
  endtask

  initial begin
    test_reset();
    test_put();
    test_ctrl();
    test_back_to_back();
    test_wrap();
    test_scroll();
    test_ofs_wrap();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
